// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, per-write acknowledge and
// overflow/underflow pulses; occupancy flags decode directly from the count.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg,  count_next;
  logic [FIFO_WIDTH-1:0] data_out_reg, data_out_next;
  logic                  wr_ack_reg,    wr_ack_next;
  logic                  overflow_reg,  overflow_next;
  logic                  underflow_reg, underflow_next;

  logic wr_accept;
  logic rd_accept;

  // Accept decisions use the pre-edge count, so a simultaneous request on an
  // empty FIFO writes but does not read, and on a full FIFO reads but does not write.
  assign full        = (count_reg == CNT_FULL);
  assign almostfull  = (count_reg == CNT_AFULL);
  assign empty       = (count_reg == CNT_ZERO);
  assign almostempty = (count_reg == CNT_ONE);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    data_out_next  = data_out_reg;
    wr_ack_next    = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;

    if (wr_accept) begin
      // Depth need not be a power of two, so wrap explicitly.
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      wr_ack_next = 1'b1;
    end else if (wr_en) begin
      overflow_next = 1'b1;
    end

    if (rd_accept) begin
      rd_ptr_next   = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      data_out_next = mem[rd_ptr_reg];
    end else if (rd_en) begin
      underflow_next = 1'b1;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      data_out_reg  <= data_out_next;
      wr_ack_reg    <= wr_ack_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is left out of reset so it maps onto block RAM; stale words are
  // unreachable because the pointers and count restart at zero.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  assign data_out  = data_out_reg;
  assign wr_ack    = wr_ack_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
